seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit multiplexed 7-segment scan controller with shadow/active digit tables
module seg_scan_ctrl #(
  parameter logic [15:0] SCAN_CNT = 16'd50000,
  parameter logic [7:0]  GAP_CNT  = 8'd50
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       wr_en,
  input  logic       commit,
  output logic       commit_done,
  output logic       frame_tick,
  output logic [5:0] sel,
  output logic [7:0] seg_led
);

  typedef enum logic {ST_SHOW, ST_GAP} state_t;

  // Table entry layout: {en, dp, data[3:0]}
  logic [5:0]  r_shadow [6];
  logic [5:0]  r_active [6];
  logic        r_pending;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic        w_frame_wrap;
  logic        w_show_tc;
  logic        w_gap_tc;
  logic        w_wr_fire;
  logic [5:0]  w_cur;
  logic [5:0]  w_sel_nxt;
  logic [7:0]  w_seg_nxt;
  logic [6:0]  w_hex;
  logic [5:0]  r_sel;
  logic [7:0]  r_seg;

  assign w_show_tc = (r_cnt == SCAN_CNT - 16'd1);
  assign w_gap_tc  = (r_cnt == {8'd0, GAP_CNT} - 16'd1);
  // Writes are refused while a commit waits so the pending snapshot stays frozen
  assign w_wr_fire = wr_valid & ~r_pending;
  assign w_cur     = r_active[r_idx];

  assign wr_ready    = ~r_pending;
  assign frame_tick  = w_frame_wrap;
  assign commit_done = w_frame_wrap & r_pending;
  assign sel         = r_sel;
  assign seg_led     = r_seg;

  // Next-state logic: SHOW on-time, GAP blanking, digit index advances after each gap
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 16'd1;
    w_idx_nxt    = r_idx;
    w_frame_wrap = 1'b0;
    case (r_state)
      ST_SHOW: begin
        if (w_show_tc) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = 16'd0;
        end
      end
      ST_GAP: begin
        if (w_gap_tc) begin
          w_state_nxt  = ST_SHOW;
          w_cnt_nxt    = 16'd0;
          w_idx_nxt    = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
          w_frame_wrap = (r_idx == 3'd5);
        end
      end
      default: begin
        w_state_nxt = ST_SHOW;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // FSM state, counter and digit index registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_SHOW;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Shadow/active tables and commit handshake; the copy happens only at a frame wrap
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 6; i++) begin
        r_shadow[i] <= 6'd0;
        r_active[i] <= 6'd0;
      end
      r_pending <= 1'b0;
    end else begin
      if (w_wr_fire && (wr_addr < 3'd6)) begin
        r_shadow[wr_addr] <= {wr_en, wr_dp, wr_data};
      end
      if (w_frame_wrap && r_pending) begin
        for (int i = 0; i < 6; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_pending <= 1'b0;
      end else if (commit && !r_pending) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Hex to active-low segment pattern (g..a) for the digit currently selected
  always_comb begin
    w_hex = 7'h7F;
    case (w_cur[3:0])
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  // Drive pattern: lit only during SHOW of an enabled digit, blank otherwise
  always_comb begin
    w_sel_nxt = 6'h3F;
    w_seg_nxt = 8'hFF;
    if (r_state == ST_SHOW && w_cur[5]) begin
      w_sel_nxt = ~(6'd1 << r_idx);
      w_seg_nxt = {~w_cur[4], w_hex};
    end
  end

  // Registered pins, one clock behind the FSM so the pads see glitch-free levels
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_sel <= 6'h3F;
      r_seg <= 8'hFF;
    end else begin
      r_sel <= w_sel_nxt;
      r_seg <= w_seg_nxt;
    end
  end

endmodule
